// File: rtl/mem_phase_ctrl.sv
// mem_phase_ctrl
//   Splits each CPU cycle into RATIO fast-clock phases so a single shared
//   memory port serves the instruction fetch (phase 0), the data load
//   (phase 2) and the data store (phase RATIO-1). The divided CPU clock is
//   generated from the same phase counter, so a CPU rising edge always
//   coincides with entry to phase 0. memBusy stretches the current phase.
//
// Ports
//   clk        fast memory clock, all registers on its rising edge
//   rst        synchronous reset, active low
//   cpuClk     registered divided CPU clock
//   phase      current phase index, 0..RATIO-1
//   insnAddr   CPU fetch address         insnOut   registered instruction
//   dataAddr   CPU data address          dataOut   registered load data
//   dataIn     CPU store data            dataWE    CPU store request
//   memAddr    shared port address       memWData  shared port write data
//   memRE      shared port read strobe   memWE     shared port write strobe
//   memRData   read data, valid the cycle after an accepted read
//   memBusy    stall request from the memory side
//   stallCount saturating count of stalled cycles
module mem_phase_ctrl #(
    parameter int RATIO      = 4,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     cpuClk,
    output logic [$clog2(RATIO)-1:0] phase,
    input  logic [ADDR_WIDTH-1:0]    insnAddr,
    output logic [DATA_WIDTH-1:0]    insnOut,
    input  logic [ADDR_WIDTH-1:0]    dataAddr,
    input  logic [DATA_WIDTH-1:0]    dataIn,
    input  logic                     dataWE,
    output logic [DATA_WIDTH-1:0]    dataOut,
    output logic [ADDR_WIDTH-1:0]    memAddr,
    output logic [DATA_WIDTH-1:0]    memWData,
    output logic                     memRE,
    output logic                     memWE,
    input  logic [DATA_WIDTH-1:0]    memRData,
    input  logic                     memBusy,
    output logic [15:0]              stallCount
);

    localparam int PW = $clog2(RATIO);
    localparam logic [PW-1:0] PH_FETCH   = '0;
    localparam logic [PW-1:0] PH_ICAP    = PW'(1);
    localparam logic [PW-1:0] PH_LOAD    = PW'(2);
    localparam logic [PW-1:0] PH_DCAP    = PW'(3);
    localparam logic [PW-1:0] PH_STORE   = PW'(RATIO - 1);
    localparam logic [PW-1:0] PH_HALF    = PW'(RATIO / 2);

    logic [PW-1:0]         phaseNext;
    logic                  cpuClkNext;
    logic [DATA_WIDTH-1:0] insnNext;
    logic [DATA_WIDTH-1:0] dataNext;
    logic [15:0]           stallNext;

    // Next-state logic: a busy cycle freezes everything except the stall
    // counter, so a stretched phase neither skips nor repeats an access.
    always_comb begin
        phaseNext  = phase;
        cpuClkNext = cpuClk;
        insnNext   = insnOut;
        dataNext   = dataOut;
        stallNext  = stallCount;
        if (memBusy) begin
            if (stallCount != '1) begin
                stallNext = stallCount + 16'd1;
            end
        end else begin
            phaseNext  = (phase == PH_STORE) ? '0 : phase + PW'(1);
            cpuClkNext = (phaseNext < PH_HALF);
            // Read data arrives the phase after the read strobe, so capture
            // happens when leaving the phase that follows each read.
            if (phase == PH_ICAP) begin
                insnNext = memRData;
            end
            if (phase == PH_DCAP) begin
                dataNext = memRData;
            end
        end
    end

    // Shared port steering. Strobes are gated by rst so the reset phase
    // (RATIO-1, the store phase) can never emit a write.
    always_comb begin
        memAddr  = (phase == PH_FETCH) ? insnAddr : dataAddr;
        memWData = dataIn;
        memRE    = rst && !memBusy && ((phase == PH_FETCH) || (phase == PH_LOAD));
        memWE    = rst && !memBusy && dataWE && (phase == PH_STORE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            phase      <= PH_STORE;
            cpuClk     <= 1'b0;
            insnOut    <= '0;
            dataOut    <= '0;
            stallCount <= '0;
        end else begin
            phase      <= phaseNext;
            cpuClk     <= cpuClkNext;
            insnOut    <= insnNext;
            dataOut    <= dataNext;
            stallCount <= stallNext;
        end
    end

endmodule

// File: tb/tb_mem_phase_ctrl.sv
// Bench for mem_phase_ctrl: one RATIO=4 and one RATIO=8 instance share the
// CPU-side stimulus; each has its own memory and a reference model that
// tracks phase, captured data and memory contents at CPU-transaction level.
module tb_mem_phase_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [15:0] insnAddr;
    logic [15:0] dataAddr;
    logic [31:0] dataIn;
    logic        dataWE;
    logic        preReq;

    logic        cpuClk[2];
    logic [1:0]  phaseA;
    logic [2:0]  phaseB;
    logic [31:0] insnOut[2];
    logic [31:0] dataOut[2];
    logic [15:0] memAddr[2];
    logic [31:0] memWData[2];
    logic        memRE[2];
    logic        memWE[2];
    logic [31:0] memRData[2] = '{32'd0, 32'd0};
    logic        memBusy[2];
    logic [15:0] stallCount[2];

    mem_phase_ctrl #(.RATIO(4), .ADDR_WIDTH(16), .DATA_WIDTH(32)) dut4 (
        .clk(clk), .rst(rst), .cpuClk(cpuClk[0]), .phase(phaseA),
        .insnAddr(insnAddr), .insnOut(insnOut[0]),
        .dataAddr(dataAddr), .dataIn(dataIn), .dataWE(dataWE), .dataOut(dataOut[0]),
        .memAddr(memAddr[0]), .memWData(memWData[0]), .memRE(memRE[0]), .memWE(memWE[0]),
        .memRData(memRData[0]), .memBusy(memBusy[0]), .stallCount(stallCount[0])
    );

    mem_phase_ctrl #(.RATIO(8), .ADDR_WIDTH(16), .DATA_WIDTH(32)) dut8 (
        .clk(clk), .rst(rst), .cpuClk(cpuClk[1]), .phase(phaseB),
        .insnAddr(insnAddr), .insnOut(insnOut[1]),
        .dataAddr(dataAddr), .dataIn(dataIn), .dataWE(dataWE), .dataOut(dataOut[1]),
        .memAddr(memAddr[1]), .memWData(memWData[1]), .memRE(memRE[1]), .memWE(memWE[1]),
        .memRData(memRData[1]), .memBusy(memBusy[1]), .stallCount(stallCount[1])
    );

    // Memories attached to each shared port, driven only by the DUT strobes.
    bit [31:0] envMem[2][65536];
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (preReq) begin
                envMem[k][16'h0010] <= 32'hDEADBEEF;
            end else begin
                if (memRE[k]) memRData[k] <= envMem[k][memAddr[k]];
                if (memWE[k]) envMem[k][memAddr[k]] <= memWData[k];
            end
        end
    end

    // Reference model state.
    int        ratio[2] = '{4, 8};
    bit [31:0] refMem[2][65536];
    int        mPhase[2];
    bit        mClk[2];
    bit [31:0] mInsn[2];
    bit [31:0] mData[2];
    bit [31:0] mLast[2];
    int        mStall[2];
    int        weCnt[2];

    int asserts = 0;
    int fails   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        asserts++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        for (int k = 0; k < 2; k++) begin
            mPhase[k] = ratio[k] - 1;
            mClk[k]   = 1'b0;
            mInsn[k]  = '0;
            mData[k]  = '0;
            mStall[k] = 0;
        end
    endtask

    // One fast-clock edge of the CPU-level behaviour, from current inputs.
    task automatic modelEdge();
        for (int k = 0; k < 2; k++) begin
            if (!rst) begin
                mPhase[k] = ratio[k] - 1;
                mClk[k]   = 1'b0;
                mInsn[k]  = '0;
                mData[k]  = '0;
                mStall[k] = 0;
            end else if (memBusy[k]) begin
                mStall[k] = (mStall[k] < 65535) ? mStall[k] + 1 : 65535;
            end else begin
                if (mPhase[k] == 0) mLast[k] = refMem[k][insnAddr];
                if (mPhase[k] == 2) mLast[k] = refMem[k][dataAddr];
                if (mPhase[k] == 1) mInsn[k] = mLast[k];
                if (mPhase[k] == 3) mData[k] = mLast[k];
                if (mPhase[k] == ratio[k] - 1 && dataWE) refMem[k][dataAddr] = dataIn;
                mPhase[k] = (mPhase[k] + 1) % ratio[k];
                mClk[k]   = (mPhase[k] < ratio[k] / 2);
            end
        end
    endtask

    task automatic checkComb();
        for (int k = 0; k < 2; k++) begin
            string p;
            bit    live;
            p    = $sformatf("R%0d.", ratio[k]);
            live = rst && !memBusy[k];
            chk({p, "memAddr"}, memAddr[k], (mPhase[k] == 0) ? insnAddr : dataAddr);
            chk({p, "memRE"}, memRE[k], live && (mPhase[k] == 0 || mPhase[k] == 2));
            chk({p, "memWE"}, memWE[k], live && dataWE && (mPhase[k] == ratio[k] - 1));
            if (mPhase[k] == ratio[k] - 1) chk({p, "memWData"}, memWData[k], dataIn);
            if (memWE[k] === 1'b1) weCnt[k]++;
        end
    endtask

    task automatic checkRegs();
        for (int k = 0; k < 2; k++) begin
            string p;
            p = $sformatf("R%0d.", ratio[k]);
            if (k == 0) chk({p, "phase"}, phaseA, mPhase[k]);
            else        chk({p, "phase"}, phaseB, mPhase[k]);
            chk({p, "cpuClk"}, cpuClk[k], mClk[k]);
            chk({p, "insnOut"}, insnOut[k], mInsn[k]);
            chk({p, "dataOut"}, dataOut[k], mData[k]);
            chk({p, "stallCount"}, stallCount[k], mStall[k]);
        end
    endtask

    // Called right after a falling edge with inputs already applied.
    task automatic cycle();
        #1;
        checkComb();
        modelEdge();
        @(posedge clk);
        #1;
        checkRegs();
        @(negedge clk);
    endtask

    int        expPh[5] = '{0, 1, 2, 3, 0};
    bit        expCk[5] = '{1, 1, 0, 0, 1};
    bit        expRe[5] = '{0, 1, 0, 1, 0};

    initial begin
        rst        = 1'b0;
        insnAddr   = '0;
        dataAddr   = '0;
        dataIn     = '0;
        dataWE     = 1'b0;
        memBusy[0] = 1'b0;
        memBusy[1] = 1'b0;
        preReq     = 1'b1;
        @(negedge clk);
        preReq = 1'b0;
        @(negedge clk);
        refMem[0][16'h0010] = 32'hDEADBEEF;
        refMem[1][16'h0010] = 32'hDEADBEEF;
        modelReset();

        // Reset values, with a store request pending in the store phase.
        dataWE = 1'b1;
        cycle();
        chk("reset.phase", phaseA, 2'd3);
        chk("reset.cpuClk", cpuClk[0], 1'b0);
        dataWE = 1'b0;

        // Release: phase/clock sequence and fetch of 0xDEADBEEF.
        rst      = 1'b1;
        insnAddr = 16'h0010;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("seq.memRE", memRE[0], expRe[i]);
            cycle();
            chk("seq.phase", phaseA, expPh[i]);
            chk("seq.cpuClk", cpuClk[0], expCk[i]);
            chk("seq.insnOut", insnOut[0], (i >= 2) ? 32'hDEADBEEF : 32'h0);
        end
        chk("seq.R8.phase", phaseB, 3'd4);

        // Store then load back through the shared port.
        dataAddr = 16'h0100;
        dataIn   = 32'h12345678;
        dataWE   = 1'b1;
        weCnt[0] = 0;
        weCnt[1] = 0;
        repeat (4) cycle();
        chk("store.R4.weCount", weCnt[0], 1);
        chk("store.R8.weCount", weCnt[1], 1);
        chk("store.R4.memory", envMem[0][16'h0100], 32'h12345678);
        dataWE = 1'b0;
        dataIn = 32'h0BADF00D;
        repeat (4) cycle();
        chk("load.R4.dataOut", dataOut[0], 32'h12345678);
        chk("load.R8.dataOut", dataOut[1], 32'h12345678);

        // Three busy cycles in phase 2 of the RATIO=4 instance.
        repeat (2) cycle();
        chk("busy.phase0", phaseA, 2'd2);
        memBusy[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("busy.memRE", memRE[0], 1'b0);
            cycle();
            chk("busy.phase", phaseA, 2'd2);
        end
        memBusy[0] = 1'b0;
        cycle();
        chk("busy.stallCount", stallCount[0], 16'd3);
        chk("busy.dataOut", dataOut[0], 32'h12345678);
        chk("busy.resume", phaseA, 2'd3);

        // Reset asserted in phase 3 with a store pending.
        dataWE = 1'b1;
        rst    = 1'b0;
        #1;
        chk("midrst.memWE", memWE[0], 1'b0);
        cycle();
        chk("midrst.dataOut", dataOut[0], 32'h0);
        chk("midrst.stallCount", stallCount[0], 16'd0);
        rst = 1'b1;
        cycle();
        chk("release.phase", phaseA, 2'd0);
        chk("release.cpuClk", cpuClk[0], 1'b1);

        // RATIO=8: clock high in phases 0..3, store only in phase 7.
        chk("r8.start", phaseB, 3'd0);
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("r8.cpuClk", cpuClk[1], i < 4);
            chk("r8.memWE", memWE[1], i == 7);
            cycle();
        end
        dataWE = 1'b0;

        // Randomized traffic, stalls and occasional resets.
        for (int n = 0; n < 400; n++) begin
            insnAddr   = 16'h0200 + 16'($urandom_range(0, 15));
            dataAddr   = 16'h0200 + 16'($urandom_range(0, 15));
            dataIn     = $urandom;
            dataWE     = $urandom_range(0, 1) == 1;
            memBusy[0] = $urandom_range(0, 3) == 0;
            memBusy[1] = $urandom_range(0, 3) == 0;
            rst        = $urandom_range(0, 59) != 0;
            cycle();
        end

        // Stall counter saturation.
        rst        = 1'b1;
        memBusy[0] = 1'b1;
        memBusy[1] = 1'b1;
        repeat (66000) @(posedge clk);
        for (int k = 0; k < 2; k++) mStall[k] = 65535;
        @(negedge clk);
        checkRegs();
        cycle();
        chk("sat.R4", stallCount[0], 16'hFFFF);
        memBusy[0] = 1'b0;
        memBusy[1] = 1'b0;
        cycle();
        chk("sat.hold", stallCount[0], 16'hFFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule

// File: doc/mem_phase_ctrl.md
MEM_PHASE_CTRL -- requirements
Module: mem_phase_ctrl

Interface
REQ-001 Parameter RATIO, default 4, SHALL set fast-clock cycles per CPU cycle; legal values are even, 4..16.
REQ-002 Parameter ADDR_WIDTH, default 16, SHALL set the address width of every address port.
REQ-003 Parameter DATA_WIDTH, default 32, SHALL set the width of instruction and data paths.
REQ-004 Port clk, input, 1, SHALL be the single fast memory clock; every register is clocked on its rising edge.
REQ-005 Port rst, input, 1, SHALL be a synchronous, active-low reset (0 = reset).
REQ-006 Port cpuClk, output, 1, SHALL be the registered, divided CPU clock.
REQ-007 Port phase, output, $clog2(RATIO), SHALL be the current phase index.
REQ-008 Port insnAddr, input, ADDR_WIDTH, SHALL be the CPU fetch address.
REQ-009 Port insnOut, output, DATA_WIDTH, SHALL be the registered instruction returned to the CPU.
REQ-010 Port dataAddr, input, ADDR_WIDTH, SHALL be the CPU data address.
REQ-011 Port dataIn, input, DATA_WIDTH, SHALL be the CPU store data.
REQ-012 Port dataWE, input, 1, SHALL be the CPU store request.
REQ-013 Port dataOut, output, DATA_WIDTH, SHALL be the registered load data returned to the CPU.
REQ-014 Ports memAddr (out, ADDR_WIDTH), memWData (out, DATA_WIDTH), memRE (out, 1), memWE (out, 1) SHALL drive the shared memory port.
REQ-015 Ports memRData (in, DATA_WIDTH) and memBusy (in, 1) SHALL carry read data and the stall request from the shared memory port.
REQ-016 Port stallCount, output, 16, SHALL report the number of stalled cycles.

Function
REQ-017 The phase counter SHALL advance 0..RATIO-1 and wrap to 0, advancing only on cycles with memBusy=0.
REQ-018 The cpuClk register SHALL take next value 1 when the next phase < RATIO/2, else 0, so a CPU rising edge coincides with entry to phase 0.
REQ-019 Phase 0 SHALL drive memAddr=insnAddr and memRE=!memBusy.
REQ-020 Phase 2 SHALL drive memAddr=dataAddr and memRE=!memBusy.
REQ-021 Phase RATIO-1 SHALL drive memAddr=dataAddr, memWData=dataIn, and memWE=dataWE&&!memBusy.
REQ-022 In all other phases memAddr SHALL equal dataAddr, with memRE=0 and memWE=0.
REQ-023 memWE SHALL be asserted in at most one accepted cycle per CPU cycle, never outside phase RATIO-1, and never while rst=0.
REQ-024 memRData SHALL be valid the cycle after an accepted read (memRE=1) and SHALL hold until the next accepted read.
REQ-025 On the edge leaving phase 1, insnOut SHALL load memRData; otherwise insnOut holds.
REQ-026 On the edge leaving phase 3, dataOut SHALL load memRData; otherwise dataOut holds.
REQ-027 When RATIO=4, the phase-3 load capture and the phase-3 write SHALL coexist, with the read returning pre-write data.
REQ-028 While memBusy=1: phase, cpuClk, insnOut and dataOut SHALL hold, memRE=0 and memWE=0, and stallCount SHALL increment, saturating at 0xFFFF.
REQ-029 A memBusy assertion of any length SHALL only stretch the current phase; no access is skipped or repeated once accepted.

Reset
REQ-030 While rst=0: phase=RATIO-1, cpuClk=0, insnOut=0, dataOut=0, stallCount=0, memRE=0, memWE=0.
REQ-031 The first edge with rst=1 SHALL move phase to 0 and cpuClk to 1, producing one clean CPU rising edge.
REQ-032 A reset asserted mid-cycle SHALL abandon any pending access; no memWE pulse SHALL occur on or after the reset edge.

Verification
REQ-033 Reset then free-run, RATIO=4, memBusy=0 -> phase sequence 3,0,1,2,3,0; cpuClk sequence 0,1,1,0,0,1; memRE=1 in phases 0 and 2 only.
REQ-034 insnAddr=0x0010, memory[0x0010]=0xDEADBEEF -> insnOut=0xDEADBEEF from phase 2 of the same CPU cycle onward.
REQ-035 dataAddr=0x0100, dataIn=0x12345678, dataWE=1 -> exactly one memWE pulse in phase 3 with memAddr=0x0100; a load from 0x0100 in the next CPU cycle gives dataOut=0x12345678.
REQ-036 memBusy=1 for 3 cycles in phase 2 -> phase stays 2 for 4 cycles, memRE=0 while busy, stallCount=3, no change to dataOut.
REQ-037 rst=0 asserted during phase 3 with dataWE=1 -> memWE=0 on that cycle, all outputs at reset values; RATIO=8 rerun -> cpuClk high in phases 0..3, write in phase 7.
REQ-038 Hold memBusy=1 for 70000 cycles -> stallCount saturates at 0xFFFF and does not wrap.
